// File: rtl/pong_score_keeper.sv
// Match control for pong: goal pulses in, two saturating 4-bit scores and a serve/point/game-over freeze out.
// Optional feature: define PONG_WIN_BY_TWO_EN to require a two-point lead (a score saturated at 15 always wins).
module pong_score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal1,
  input  logic       goal2,
  input  logic       serve,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       freeze,
  output logic       game_over,
  output logic       winner,
  output logic       point_pulse
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [3:0]        WIN_Q     = 4'(WIN_SCORE);
  localparam logic [3:0]        SCORE_MAX = 4'hF;

  typedef enum logic [1:0] {
    WAIT_SERVE = 2'd0,
    PLAY       = 2'd1,
    POINT      = 2'd2,
    OVER       = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        score1_q, score1_d;
  logic [3:0]        score2_q, score2_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              winner_q, winner_d;
  logic              pulse_q, pulse_d;
  logic              freeze_q, freeze_d;
  logic              over_q, over_d;
  logic              serve_d_q;
  logic              serve_arm_q;
  logic              serve_edge;
  logic              win1, win2;

  // serve_arm_q only rises once serve has been sampled low after reset, so a
  // button held through reset release never counts as a fresh press.
  assign serve_edge = serve & ~serve_d_q & serve_arm_q;

`ifdef PONG_WIN_BY_TWO_EN
  assign win1 = (score1_q == SCORE_MAX) ||
                ((score1_q >= WIN_Q) && ({1'b0, score1_q} >= ({1'b0, score2_q} + 5'd2)));
  assign win2 = (score2_q == SCORE_MAX) ||
                ((score2_q >= WIN_Q) && ({1'b0, score2_q} >= ({1'b0, score1_q} + 5'd2)));
`else
  assign win1 = (score1_q >= WIN_Q);
  assign win2 = (score2_q >= WIN_Q);
`endif

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    pulse_d  = 1'b0;
    case (state_q)
      WAIT_SERVE: begin
        if (serve_edge) state_d = PLAY;
      end
      PLAY: begin
        if (goal1 || goal2) begin
          // Simultaneous goals replay the rally: no score change, but still a point.
          if (goal1 && !goal2 && (score1_q != SCORE_MAX)) score1_d = score1_q + 4'd1;
          if (goal2 && !goal1 && (score2_q != SCORE_MAX)) score2_d = score2_q + 4'd1;
          pulse_d = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = POINT;
        end
      end
      POINT: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_ONE;
        end else if (win1) begin
          winner_d = 1'b0;
          state_d  = OVER;
        end else if (win2) begin
          winner_d = 1'b1;
          state_d  = OVER;
        end else begin
          state_d = WAIT_SERVE;
        end
      end
      OVER: begin
        if (serve_edge) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          state_d  = WAIT_SERVE;
        end
      end
      default: state_d = WAIT_SERVE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the scores.
  assign freeze_d = (state_d != PLAY);
  assign over_d   = (state_d == OVER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_SERVE;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      hold_q      <= '0;
      winner_q    <= 1'b0;
      pulse_q     <= 1'b0;
      freeze_q    <= 1'b1;
      over_q      <= 1'b0;
      serve_d_q   <= 1'b0;
      serve_arm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      hold_q      <= hold_d;
      winner_q    <= winner_d;
      pulse_q     <= pulse_d;
      freeze_q    <= freeze_d;
      over_q      <= over_d;
      serve_d_q   <= serve;
      serve_arm_q <= serve_arm_q | ~serve;
    end
  end

  assign score1      = score1_q;
  assign score2      = score2_q;
  assign freeze      = freeze_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign point_pulse = pulse_q;

endmodule

// File: doc/pong_score_keeper.md
# pong_score_keeper

Match-control stage between the ball/paddle animation and the seven-segment display controller. It consumes single-cycle goal pulses from the animation, keeps both 4-bit player scores, and presents them to the display digits. A serve/point/game-over state machine produces a `freeze` signal that holds the ball between rallies and after a win, and clears the match on a serve press after game over.

## Interface
- `WIN_SCORE`, default 9: score that ends the match; legal range 1..15.
- `HOLD_CYCLES`, default 50_000_000: cycles the ball stays frozen after a point (1 s at 50 MHz); must be ≥1.
- `clk` in 1: system clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset; low forces every register to its reset value immediately.
- `goal1` in 1: single-cycle pulse, player 1 scored.
- `goal2` in 1: single-cycle pulse, player 2 scored.
- `serve` in 1: serve button, synchronous and already debounced; level input, rising edge used.
- `score1` out 4: player 1 score, unsigned binary, display digit.
- `score2` out 4: player 2 score, unsigned binary, display digit.
- `freeze` out 1: high means the animation must hold the ball at the centre.
- `game_over` out 1: high while a match result is displayed.
- `winner` out 1: 0 = player 1, 1 = player 2; valid only while `game_over`=1.
- `point_pulse` out 1: one-cycle strobe on the cycle the scores update.

## Operation
- Serve edge: `serve_d` register; `serve_edge = serve & ~serve_d`. `serve` held high produces one edge only.
- States: WAIT_SERVE, PLAY, POINT, OVER. Reset state is WAIT_SERVE.
- WAIT_SERVE: `freeze`=1. Goals are ignored. `serve_edge` moves to PLAY.
- PLAY: `freeze`=0.
  - `goal1` only: `score1`+1, go to POINT.
  - `goal2` only: `score2`+1, go to POINT.
  - `goal1` and `goal2` in the same cycle: no score change, go to POINT (replayed rally); `point_pulse` still fires.
  - `serve_edge` in PLAY is ignored.
- POINT: `freeze`=1. The hold counter loads `HOLD_CYCLES-1` on entry and counts down. At 0:
  - If the win condition is met, go to OVER.
  - Otherwise, go to WAIT_SERVE.
  - Goals and serve edges are ignored throughout POINT.
- Win condition: `score1` ≥ `WIN_SCORE` → winner 0; `score2` ≥ `WIN_SCORE` → winner 1. Only one player can satisfy it at a time, because only one score changes per point.
- OVER: `freeze`=1, `game_over`=1, `winner` held. On `serve_edge`, both scores clear to 0, `game_over` clears, and the state goes to WAIT_SERVE.
- Scores saturate at 15 and never wrap.
- Reset values: `score1`=0, `score2`=0, `freeze`=1, `game_over`=0, `winner`=0, `point_pulse`=0, hold counter 0, `serve_d`=0.
- Reset low mid-POINT or mid-OVER aborts immediately to WAIT_SERVE with zeroed scores.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Goal pulse sampled at edge N: `score1`/`score2`, `point_pulse`=1 and `freeze`=1 are visible after edge N.
- `point_pulse` is high for exactly one cycle.
- `freeze` stays high for exactly `HOLD_CYCLES` cycles in POINT. It then stays high in WAIT_SERVE or OVER.
- `serve` rising and sampled at edge N (`serve_d`=0): `freeze`=0 after edge N.
- OVER→WAIT_SERVE: scores read 0 and `game_over`=0 after the same edge.
- Reset deassertion is asynchronous to `clk`. The first active edge after release behaves as WAIT_SERVE.

## Configuration
- `PONG_WIN_BY_TWO_EN` defined: the win condition additionally requires the leader's score minus the opponent's ≥ 2. A player whose score saturates at 15 wins regardless of margin.
- `PONG_WIN_BY_TWO_EN` undefined: plain first-to-`WIN_SCORE`. The difference logic is not synthesised.

## Test plan
- Reset then release, no stimulus → scores 0/0, `freeze`=1, `game_over`=0; a `goal1` pulse in WAIT_SERVE leaves `score1`=0.
- `HOLD_CYCLES`=4: serve edge, then `goal1` → `score1`=1 and `point_pulse` for 1 cycle on the next edge; `freeze` high 4 cycles in POINT, then WAIT_SERVE, `freeze` stays 1 until the next serve edge.
- Simultaneous `goal1`&`goal2` in PLAY → scores unchanged, `point_pulse`=1, POINT entered; a second goal during POINT is ignored.
- `WIN_SCORE`=3, macro undefined: player 2 scores 3 rallies → after the third hold, `game_over`=1, `winner`=1, `freeze`=1; serve edge → scores 0/0, `game_over`=0.
- `WIN_SCORE`=3, macro defined: score 3-2 → no game over; 4-2 → `game_over`=1, `winner`=0. Drive to 14-14 then 15-14 → `game_over`, `winner`=0, no wrap past 15.
- Assert `reset` low mid-POINT with scores 2/1 → outputs return immediately to reset values without a clock; `serve` held high across release yields no spurious serve.
